// File: rtl/flight_pkg.sv
// Shared types and default sizing for the cabin flight-call arbiter.
package flight_pkg;

  typedef enum logic [1:0] {
    StIdle      = 2'd0,
    StDispatch  = 2'd1,
    StServicing = 2'd2
  } state_e;

  localparam int unsigned DefNSeats    = 8;
  localparam int unsigned DefSeatW     = 3;
  localparam int unsigned DefEscCycles = 1000;
  localparam int unsigned DefCntW      = 10;

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin picker: first set request at or after ptr, wrapping.
module rr_picker #(
  parameter int unsigned N_SEATS = 8,
  parameter int unsigned SEAT_W  = 3
) (
  input  logic [N_SEATS-1:0] req,
  input  logic [SEAT_W-1:0]  ptr,
  output logic [SEAT_W-1:0]  grant_idx,
  output logic               any
);

  logic [SEAT_W-1:0] idx;

  // Walk offsets from farthest to nearest so the nearest set request wins last.
  always_comb begin
    grant_idx = '0;
    idx       = '0;
    any       = |req;
    for (int off = N_SEATS - 1; off >= 0; off--) begin
      idx = SEAT_W'((int'(ptr) + off) % N_SEATS);
      if (req[idx]) begin
        grant_idx = idx;
      end
    end
  end

endmodule

// File: rtl/flight_call_arbiter.sv
// Cabin controller sharing one attendant between seats: call-light latches,
// round-robin dispatch handshake and a sticky escalation flag for stale calls.
module flight_call_arbiter
  import flight_pkg::*;
#(
  parameter int unsigned N_SEATS    = DefNSeats,
  parameter int unsigned SEAT_W     = DefSeatW,
  parameter int unsigned ESC_CYCLES = DefEscCycles,
  parameter int unsigned CNT_W      = DefCntW
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [N_SEATS-1:0] call_button,
  input  logic [N_SEATS-1:0] cancel_button,
  input  logic               attendant_ready,
  input  logic               service_done,
  output logic [N_SEATS-1:0] light_state,
  output logic               dispatch_valid,
  output logic [SEAT_W-1:0]  dispatch_seat,
  output logic               busy,
  output logic               escalate
);

  localparam logic [CNT_W-1:0]  EscMax   = CNT_W'(ESC_CYCLES);
  localparam logic [SEAT_W-1:0] LastSeat = SEAT_W'(N_SEATS - 1);

  state_e             state_q, state_d;
  logic [N_SEATS-1:0] light_q, light_d, clr;
  logic [SEAT_W-1:0]  seat_q, seat_d;
  logic [SEAT_W-1:0]  rr_ptr_q, rr_ptr_d;
  logic [CNT_W-1:0]   wait_cnt_q, wait_cnt_d;
  logic               esc_q, esc_d;
  logic [SEAT_W-1:0]  grant_idx;
  logic               any_req;
  logic               enter_svc;

  rr_picker #(
    .N_SEATS (N_SEATS),
    .SEAT_W  (SEAT_W)
  ) u_rr_picker (
    .req       (light_q),
    .ptr       (rr_ptr_q),
    .grant_idx (grant_idx),
    .any       (any_req)
  );

  // A fresh call always wins over cancel and over completion clear.
  always_comb begin
    clr = '0;
    for (int i = 0; i < N_SEATS; i++) begin
      clr[i] = service_done && (state_q == StServicing) && (seat_q == SEAT_W'(i));
    end
    light_d = call_button | (light_q & ~cancel_button & ~clr);
  end

  always_comb begin
    state_d  = state_q;
    seat_d   = seat_q;
    rr_ptr_d = rr_ptr_q;
    unique case (state_q)
      StIdle: begin
        if (any_req) begin
          state_d = StDispatch;
          seat_d  = grant_idx;
        end
      end
      StDispatch: begin
        // Withdrawal of the offered seat takes priority over the handshake.
        if (!light_d[seat_q]) begin
          state_d = StIdle;
        end else if (attendant_ready) begin
          state_d = StServicing;
        end
      end
      StServicing: begin
        if (service_done) begin
          state_d  = StIdle;
          rr_ptr_d = (seat_q == LastSeat) ? '0 : seat_q + SEAT_W'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  assign enter_svc = (state_q != StServicing) && (state_d == StServicing);

  always_comb begin
    wait_cnt_d = wait_cnt_q;
    esc_d      = esc_q;
    if (enter_svc || (light_q == '0)) begin
      wait_cnt_d = '0;
      esc_d      = 1'b0;
    end else if ((state_q != StServicing) && (wait_cnt_q < EscMax)) begin
      wait_cnt_d = wait_cnt_q + CNT_W'(1);
      if (wait_cnt_d == EscMax) begin
        esc_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StIdle;
      light_q    <= '0;
      seat_q     <= '0;
      rr_ptr_q   <= '0;
      wait_cnt_q <= '0;
      esc_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      light_q    <= light_d;
      seat_q     <= seat_d;
      rr_ptr_q   <= rr_ptr_d;
      wait_cnt_q <= wait_cnt_d;
      esc_q      <= esc_d;
    end
  end

  assign light_state    = light_q;
  assign dispatch_valid = (state_q == StDispatch);
  assign busy           = (state_q == StServicing);
  assign dispatch_seat  = seat_q;
  assign escalate       = esc_q;

endmodule

// File: tb/tb_flight_call_arbiter.sv
// Directed self-checking bench for flight_call_arbiter (ESC_CYCLES shortened to 5).
module tb_flight_call_arbiter;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] call_button;
  logic [7:0] cancel_button;
  logic       attendant_ready;
  logic       service_done;
  logic [7:0] light_state;
  logic       dispatch_valid;
  logic [2:0] dispatch_seat;
  logic       busy;
  logic       escalate;

  int total = 0;
  int bad   = 0;

  flight_call_arbiter #(
    .N_SEATS    (8),
    .SEAT_W     (3),
    .ESC_CYCLES (5),
    .CNT_W      (3)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .call_button     (call_button),
    .cancel_button   (cancel_button),
    .attendant_ready (attendant_ready),
    .service_done    (service_done),
    .light_state     (light_state),
    .dispatch_valid  (dispatch_valid),
    .dispatch_seat   (dispatch_seat),
    .busy            (busy),
    .escalate        (escalate)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_dv(input int exp_seat, input string tag);
    int n = 0;
    while (dispatch_valid !== 1'b1 && n < 10) begin
      tick();
      n++;
    end
    chk({tag, "_valid"}, 32'(dispatch_valid), 32'd1);
    chk({tag, "_seat"}, 32'(dispatch_seat), 32'(exp_seat));
  endtask

  // Assumes attendant_ready is held high.
  task automatic serve(input int exp_seat, input string tag);
    wait_dv(exp_seat, tag);
    tick();
    chk({tag, "_busy"}, 32'(busy), 32'd1);
    service_done = 1'b1;
    tick();
    service_done = 1'b0;
    chk({tag, "_idle"}, 32'(busy), 32'd0);
    chk({tag, "_lightclr"}, 32'(light_state[exp_seat]), 32'd0);
  endtask

  initial begin
    reset = 1'b1; call_button = '0; cancel_button = '0;
    attendant_ready = 1'b0; service_done = 1'b0;
    tick(); tick();
    reset = 1'b0;
    chk("rst_light", 32'(light_state), 32'h0);
    chk("rst_valid", 32'(dispatch_valid), 32'd0);
    chk("rst_seat", 32'(dispatch_seat), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_esc", 32'(escalate), 32'd0);

    // Single call on seat 2.
    call_button = 8'h04;
    tick();
    call_button = '0; attendant_ready = 1'b1;
    chk("t1_light", 32'(light_state), 32'h04);
    chk("t1_novalid", 32'(dispatch_valid), 32'd0);
    tick();
    chk("t1_valid", 32'(dispatch_valid), 32'd1);
    chk("t1_seat", 32'(dispatch_seat), 32'd2);
    chk("t1_notbusy", 32'(busy), 32'd0);
    tick();
    chk("t1_busy", 32'(busy), 32'd1);
    chk("t1_valid_off", 32'(dispatch_valid), 32'd0);
    service_done = 1'b1;
    tick();
    service_done = 1'b0;
    chk("t1_done_light", 32'(light_state), 32'h0);
    chk("t1_done_busy", 32'(busy), 32'd0);
    // rr_ptr is now 3, so seat 5 goes before seat 1.
    call_button = 8'h22;
    tick();
    call_button = '0;
    serve(5, "t1_ptr_a");
    serve(1, "t1_ptr_b");

    reset = 1'b1;
    tick();
    reset = 1'b0;

    // Seats 1,5,6 together, then seat 0 wraps.
    call_button = 8'h62;
    tick();
    call_button = '0;
    serve(1, "t2_s1");
    serve(5, "t2_s5");
    serve(6, "t2_s6");
    call_button = 8'h01;
    tick();
    call_button = '0;
    serve(0, "t2_s0");
    chk("t2_empty", 32'(light_state), 32'h0);

    // Call vs cancel on seat 4.
    attendant_ready = 1'b0;
    call_button = 8'h10; cancel_button = 8'h10;
    tick();
    call_button = '0; cancel_button = '0;
    chk("t3_callwins", 32'(light_state), 32'h10);
    tick();
    chk("t3_dv", 32'(dispatch_valid), 32'd1);
    chk("t3_seat", 32'(dispatch_seat), 32'd4);
    cancel_button = 8'h10;
    tick();
    cancel_button = '0;
    chk("t3_cancel_light", 32'(light_state), 32'h0);
    chk("t3_cancel_idle", 32'(dispatch_valid), 32'd0);
    call_button = 8'h10;
    tick();
    call_button = '0;
    tick();
    chk("t3b_dv", 32'(dispatch_valid), 32'd1);
    cancel_button = 8'h10; attendant_ready = 1'b1;
    tick();
    cancel_button = '0; attendant_ready = 1'b0;
    chk("t3b_nobusy", 32'(busy), 32'd0);
    chk("t3b_novalid", 32'(dispatch_valid), 32'd0);
    tick(); tick();

    // Escalation after 5 waiting cycles on seat 3.
    call_button = 8'h08;
    tick();
    call_button = '0;
    tick(); tick(); tick(); tick();
    chk("t4_esc_early", 32'(escalate), 32'd0);
    tick();
    chk("t4_esc_set", 32'(escalate), 32'd1);
    tick();
    chk("t4_esc_sticky", 32'(escalate), 32'd1);
    chk("t4_still_dv", 32'(dispatch_valid), 32'd1);
    attendant_ready = 1'b1;
    tick();
    attendant_ready = 1'b0;
    chk("t4_busy", 32'(busy), 32'd1);
    chk("t4_esc_clr", 32'(escalate), 32'd0);

    // Reset while servicing, then a stray service_done.
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("t5_light", 32'(light_state), 32'h0);
    chk("t5_busy", 32'(busy), 32'd0);
    chk("t5_valid", 32'(dispatch_valid), 32'd0);
    chk("t5_seat", 32'(dispatch_seat), 32'd0);
    chk("t5_esc", 32'(escalate), 32'd0);
    service_done = 1'b1;
    tick();
    service_done = 1'b0;
    chk("t5_ignored_busy", 32'(busy), 32'd0);
    chk("t5_ignored_dv", 32'(dispatch_valid), 32'd0);

    // Re-call on completion: seat 2 stays lit, re-served after seat 5.
    attendant_ready = 1'b1;
    call_button = 8'h24;
    tick();
    call_button = '0;
    wait_dv(2, "t6_first");
    tick();
    chk("t6_busy", 32'(busy), 32'd1);
    call_button = 8'h04; service_done = 1'b1;
    tick();
    call_button = '0; service_done = 1'b0;
    chk("t6_relit", 32'(light_state), 32'h24);
    serve(5, "t6_s5");
    serve(2, "t6_s2");
    chk("t6_empty", 32'(light_state), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
